keypad_matrix_scan: RTL and testbench

Parametrised successor to the fixed 4x4 keypad scanner: drives one-hot row strobes over an NROWS x NCOLS switch matrix, synchronises and debounces the column returns, and reports each new key as a binary code with a one-cycle `num_new` pulse. It also adds held and release indication, deterministic multi-key priority, and an optional auto-repeat. It sits between the keypad pins and the display/decoder logic, in the same slot as the earlier scanner.

---
 rtl/keypad_matrix_scan.sv | 206 ++++++++++++++++++++
 tb/tb_keypad_matrix_scan.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_matrix_scan.sv
// Row-strobed NROWS x NCOLS keypad scanner with debounced press/release reporting.
// Define KEYPAD_AUTOREPEAT_EN to build the auto-repeat of num_new while a key is held.
module keypad_matrix_scan #(
    parameter int NROWS         = 4,
    parameter int NCOLS         = 4,
    parameter int DWELL         = 4,
    parameter int DEBOUNCE      = 16,
    parameter int REPEAT_DELAY  = 64,
    parameter int REPEAT_PERIOD = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NCOLS-1:0]                col,
    output logic [NROWS-1:0]                rows,
    output logic [$clog2(NROWS*NCOLS)-1:0]  key_code,
    output logic                            num_new,
    output logic                            key_held,
    output logic                            key_release
);

    localparam int RW   = $clog2(NROWS);
    localparam int CLW  = (NCOLS > 1) ? $clog2(NCOLS) : 1;
    localparam int KW   = $clog2(NROWS*NCOLS);
    localparam int CMAX = (DWELL > DEBOUNCE) ? DWELL : DEBOUNCE;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {SCAN, PDEB, HELD, RDEB} state_t;

    state_t           state_reg, state_next;
    logic [NCOLS-1:0] meta_reg, cs_reg;
    logic [RW-1:0]    row_reg, row_next, row_inc;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [CLW-1:0]   kc_reg, kc_next, low_idx;
    logic [NROWS-1:0] rows_reg, rows_next;
    logic [KW-1:0]    key_code_reg, key_code_next, code_now;
    logic             num_new_reg, num_new_next;
    logic             key_held_reg, key_held_next;
    logic             key_release_reg, key_release_next;
    logic             press_accept, release_accept, repeat_fire;
    logic             key_bit;

    assign key_bit  = cs_reg[kc_reg];
    assign row_inc  = (row_reg == RW'(NROWS-1)) ? '0 : row_reg + RW'(1);
    assign code_now = KW'(row_reg) * KW'(NCOLS) + KW'(kc_reg);

    // Lowest set column wins when several keys share the strobed row.
    always_comb begin
        low_idx = '0;
        for (int i = NCOLS-1; i >= 0; i--) begin
            if (cs_reg[i]) low_idx = CLW'(i);
        end
    end

    for (genvar gi = 0; gi < NROWS; gi++) begin : g_rows
        assign rows_next[gi] = (row_next == RW'(gi));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_reg        <= '0;
            cs_reg          <= '0;
            state_reg       <= SCAN;
            row_reg         <= '0;
            cnt_reg         <= '0;
            kc_reg          <= '0;
            rows_reg        <= NROWS'(1);
            key_code_reg    <= '0;
            num_new_reg     <= 1'b0;
            key_held_reg    <= 1'b0;
            key_release_reg <= 1'b0;
        end else begin
            meta_reg        <= col;
            cs_reg          <= meta_reg;
            state_reg       <= state_next;
            row_reg         <= row_next;
            cnt_reg         <= cnt_next;
            kc_reg          <= kc_next;
            rows_reg        <= rows_next;
            key_code_reg    <= key_code_next;
            num_new_reg     <= num_new_next;
            key_held_reg    <= key_held_next;
            key_release_reg <= key_release_next;
        end
    end

    // cnt_reg is the dwell counter in SCAN and the debounce counter in PDEB/RDEB.
    always_comb begin
        state_next     = state_reg;
        row_next       = row_reg;
        cnt_next       = cnt_reg;
        kc_next        = kc_reg;
        press_accept   = 1'b0;
        release_accept = 1'b0;
        case (state_reg)
            SCAN: begin
                if (cnt_reg == CW'(DWELL-1)) begin
                    cnt_next = '0;
                    if (cs_reg == '0) begin
                        row_next = row_inc;
                    end else begin
                        kc_next    = low_idx;
                        state_next = PDEB;
                    end
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            PDEB: begin
                if (!key_bit) begin
                    state_next = SCAN;
                    row_next   = row_inc;
                    cnt_next   = '0;
                end else if (cnt_reg == CW'(DEBOUNCE-1)) begin
                    state_next   = HELD;
                    cnt_next     = '0;
                    press_accept = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            HELD: begin
                if (!key_bit) begin
                    state_next = RDEB;
                    cnt_next   = '0;
                end
            end
            RDEB: begin
                if (key_bit) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt_reg == CW'(DEBOUNCE-1)) begin
                    state_next     = SCAN;
                    row_next       = row_inc;
                    cnt_next       = '0;
                    release_accept = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = SCAN;
        endcase
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPW  = $clog2(RMAX + 1);

    logic [RPW-1:0] rep_reg, rep_next, rep_target;
    logic           rep_phase_reg, rep_phase_next;

    // Phase 0 waits out the initial delay, phase 1 runs the steady period.
    assign rep_target = rep_phase_reg ? RPW'(REPEAT_PERIOD) : RPW'(REPEAT_DELAY);

    always_comb begin
        rep_next       = rep_reg;
        rep_phase_next = rep_phase_reg;
        repeat_fire    = 1'b0;
        if (press_accept) begin
            rep_next       = '0;
            rep_phase_next = 1'b0;
        end else if (state_reg == HELD && key_bit) begin
            if (rep_reg + RPW'(1) == rep_target) begin
                repeat_fire    = 1'b1;
                rep_next       = '0;
                rep_phase_next = 1'b1;
            end else begin
                rep_next = rep_reg + RPW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rep_reg       <= '0;
            rep_phase_reg <= 1'b0;
        end else begin
            rep_reg       <= rep_next;
            rep_phase_reg <= rep_phase_next;
        end
    end
`else
    // Repeat timing parameters are inert in this build.
    if (REPEAT_DELAY < 0 || REPEAT_PERIOD < 0) begin : g_repeat_inert
    end
    assign repeat_fire = 1'b0;
`endif

    always_comb begin
        key_code_next    = key_code_reg;
        key_held_next    = key_held_reg;
        num_new_next     = press_accept | repeat_fire;
        key_release_next = release_accept;
        if (press_accept) begin
            key_code_next = code_now;
            key_held_next = 1'b1;
        end
        if (release_accept) key_held_next = 1'b0;
    end

    assign rows        = rows_reg;
    assign key_code    = key_code_reg;
    assign num_new     = num_new_reg;
    assign key_held    = key_held_reg;
    assign key_release = key_release_reg;

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// Bench for keypad_matrix_scan: a simulated switch matrix, a behavioural reference
// checked every cycle, and directed scenarios with hand-computed expectations.
module tb_keypad_matrix_scan;

    localparam int NR = 4;
    localparam int NC = 4;
    localparam int DW = 4;
    localparam int DB = 16;
    localparam int RD = 64;
    localparam int RP = 32;
    localparam int KW = $clog2(NR*NC);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [NC-1:0] col;
    logic [NR-1:0] rows;
    logic [KW-1:0] key_code;
    logic          num_new, key_held, key_release;
    logic [NR*NC-1:0] pressed = '0;

    int tests = 0;
    int fails = 0;
    int new_cnt = 0;
    int rel_cnt = 0;

    always #5 clk = ~clk;

    keypad_matrix_scan #(
        .NROWS(NR), .NCOLS(NC), .DWELL(DW), .DEBOUNCE(DB),
        .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk(clk), .reset(reset), .col(col), .rows(rows), .key_code(key_code),
        .num_new(num_new), .key_held(key_held), .key_release(key_release)
    );

    // Switch matrix: a closed switch connects its row strobe to its column line.
    always_comb begin
        col = '0;
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                if (rows[r] && pressed[r*NC+c]) col[c] = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: scan pointer, latched key, and run lengths of the synchronised column.
    logic [NC-1:0] m_s1 = '0, m_s2 = '0;
    int  m_row = 0, m_dwell = 0, m_kc = 0, m_run = 0, m_nrep = 0, m_code = 0;
    bit  m_locked = 0, m_acc = 0, m_rel_pend = 0;
    bit  m_new = 0, m_held = 0, m_rel = 0;

    function automatic int lowest(input logic [NC-1:0] v);
        for (int i = 0; i < NC; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_row = 0; m_dwell = 0; m_kc = 0; m_run = 0;
        m_nrep = 0; m_code = 0; m_locked = 0; m_acc = 0; m_rel_pend = 0;
        m_new = 0; m_held = 0; m_rel = 0;
    endtask

    task automatic model_step(input logic [NC-1:0] raw);
        logic [NC-1:0] cs;
        cs = m_s2; m_s2 = m_s1; m_s1 = raw;
        m_new = 0; m_rel = 0;
        if (!m_locked) begin
            if (m_dwell == DW-1) begin
                m_dwell = 0;
                if (cs == '0) m_row = (m_row + 1) % NR;
                else begin m_locked = 1; m_kc = lowest(cs); m_run = 0; end
            end else m_dwell++;
        end else if (!m_acc) begin
            if (cs[m_kc]) begin
                m_run++;
                if (m_run == DB) begin
                    m_acc = 1; m_new = 1; m_held = 1; m_code = m_row*NC + m_kc;
                    m_nrep = 0; m_rel_pend = 0; m_run = 0;
                end
            end else begin
                m_locked = 0; m_row = (m_row + 1) % NR; m_dwell = 0;
            end
        end else if (!m_rel_pend) begin
            if (cs[m_kc]) begin
                m_nrep++;
`ifdef KEYPAD_AUTOREPEAT_EN
                if (m_nrep >= RD && (m_nrep - RD) % RP == 0) m_new = 1;
`endif
            end else begin
                m_rel_pend = 1; m_run = 0;
            end
        end else begin
            if (cs[m_kc]) m_rel_pend = 0;
            else begin
                m_run++;
                if (m_run == DB) begin
                    m_rel = 1; m_held = 0; m_acc = 0; m_locked = 0; m_rel_pend = 0;
                    m_row = (m_row + 1) % NR; m_dwell = 0;
                end
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else model_step(col);
    end

    task automatic compare_cycle();
        logic [NR-1:0] exp_rows;
        exp_rows = NR'(1) << m_row;
        chk("rows", rows, exp_rows);
        chk("key_code", key_code, m_code);
        chk("num_new", num_new, m_new);
        chk("key_held", key_held, m_held);
        chk("key_release", key_release, m_rel);
        if (num_new === 1'b1) new_cnt++;
        if (key_release === 1'b1) rel_cnt++;
    endtask

    always @(negedge clk) compare_cycle();

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pulse(input bit want_release, input int bound, input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            tick();
            seen = want_release ? (key_release === 1'b1) : (num_new === 1'b1);
        end
        chk(name, seen, 1);
    endtask

    initial begin
        int n0, r0, exp_rep, k, hold;
        logic [NR*NC-1:0] saved;
        bit found;
        logic [NR-1:0] prev_rows;

        repeat (3) tick();
        chk("rst_rows", rows, 4'b0001);
        chk("rst_code", key_code, 0);
        chk("rst_flags", {num_new, key_held, key_release}, 3'b000);
        reset = 1'b1;
        repeat (3) tick();
        chk("scan_row0_dwell", rows, 4'b0001);
        tick();
        chk("scan_row1_step", rows, 4'b0010);

        // Single press row0/col1
        n0 = new_cnt; r0 = rel_cnt;
        pressed = '0; pressed[1] = 1'b1;
        wait_pulse(0, 100, "single_new_timeout");
        chk("single_code", key_code, 1);
        chk("single_held", key_held, 1);
        repeat (50) tick();
        chk("single_rows_frozen", rows, 4'b0001);
        chk("single_new_count", new_cnt - n0, 1);
        pressed = '0;
        wait_pulse(1, 60, "single_rel_timeout");
        chk("single_resume_row1", rows, 4'b0010);
        chk("single_code_kept", key_code, 1);
        chk("single_rel_count", rel_cnt - r0, 1);

        // Corner key row3/col3
        n0 = new_cnt;
        pressed = '0; pressed[15] = 1'b1;
        wait_pulse(0, 120, "corner_new_timeout");
        chk("corner_code", key_code, 15);
        repeat (40) tick();
        chk("corner_new_count", new_cnt - n0, 1);
        pressed = '0;
        wait_pulse(1, 60, "corner_rel_timeout");

        // Short press bounce on row2 caught by the scan sample
        found = 0; prev_rows = rows;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            found = (rows == 4'b0100) && (prev_rows != 4'b0100);
            prev_rows = rows;
        end
        chk("bounce_row2_found", found, 1);
        n0 = new_cnt;
        pressed = '0; pressed[8] = 1'b1;
        repeat (5) tick();
        pressed = '0;
        repeat (30) tick();
        chk("bounce_press_no_new", new_cnt - n0, 0);
        chk("bounce_press_not_held", key_held, 0);

        // Release bounce while held
        pressed = '0; pressed[5] = 1'b1;
        wait_pulse(0, 120, "rbounce_new_timeout");
        chk("rbounce_code", key_code, 5);
        r0 = rel_cnt;
        pressed = '0;
        repeat (5) tick();
        pressed[5] = 1'b1;
        repeat (30) tick();
        chk("rbounce_no_rel", rel_cnt - r0, 0);
        chk("rbounce_still_held", key_held, 1);
        pressed = '0;
        wait_pulse(1, 60, "rbounce_rel_timeout");

        // Two keys in row2 (col=0101), then col3 added while held
        n0 = new_cnt;
        pressed = '0; pressed[8] = 1'b1; pressed[10] = 1'b1;
        wait_pulse(0, 120, "two_new_timeout");
        chk("two_code", key_code, 8);
        pressed[11] = 1'b1;
        repeat (30) tick();
        chk("two_new_count", new_cnt - n0, 1);
        pressed = '0;
        wait_pulse(1, 60, "two_rel_timeout");

        // Long hold: repeats only in the auto-repeat build
        n0 = new_cnt;
        pressed = '0; pressed[6] = 1'b1;
        wait_pulse(0, 120, "rep_new_timeout");
        repeat (RD + 3*RP + 4) tick();
`ifdef KEYPAD_AUTOREPEAT_EN
        exp_rep = 5;
`else
        exp_rep = 1;
`endif
        chk("rep_new_count", new_cnt - n0, exp_rep);
        chk("rep_code", key_code, 6);
        pressed = '0;
        wait_pulse(1, 60, "rep_rel_timeout");

        // Reset mid-scan
        repeat (6) tick();
        reset = 1'b0;
        #1;
        chk("midrst_rows", rows, 4'b0001);
        chk("midrst_code", key_code, 0);
        chk("midrst_flags", {num_new, key_held, key_release}, 3'b000);
        repeat (2) tick();
        reset = 1'b1;

        // Randomised presses, dropouts and multi-key combinations
        for (int it = 0; it < 40; it++) begin
            pressed = '0;
            k = $urandom_range(0, NR*NC-1);
            pressed[k] = 1'b1;
            if ($urandom_range(0, 3) == 0) pressed[$urandom_range(0, NR*NC-1)] = 1'b1;
            hold = $urandom_range(1, 120);
            repeat (hold) tick();
            if ($urandom_range(0, 1) == 1) begin
                saved = pressed;
                pressed = '0;
                repeat ($urandom_range(1, 24)) tick();
                pressed = saved;
                repeat ($urandom_range(1, 60)) tick();
            end
            pressed = '0;
            repeat ($urandom_range(1, 80)) tick();
        end

        repeat (60) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
